// File: rtl/fpu_ret_collect.sv
`default_nettype none
// ============================================================================
// Module   : fpu_ret_collect
// Brief    : In-order retire-status queue for the three FP add ports, with
//            sticky exception flags and a registered almost-full stall.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_ret_collect #(
    parameter int DEPTH    = 8,
    parameter int STALL_TH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [13:0]                u1_ret,
    input  logic                       u1_ret_en,
    input  logic [13:0]                u3_ret,
    input  logic                       u3_ret_en,
    input  logic [13:0]                u5_ret,
    input  logic                       u5_ret_en,
    output logic [13:0]                out_ret,
    output logic [1:0]                 out_port,
    output logic                       out_vld,
    input  logic                       out_rdy,
    input  logic                       flags_clr,
    output logic [5:0]                 fp_flags,
    output logic                       stall,
    output logic                       ovf_err,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [13:0]     r_mem_ret  [DEPTH];
    logic [1:0]      r_mem_port [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic [5:0]      r_flags;
    logic            r_stall;
    logic            r_ovf;

    logic            w_pop;
    logic [c_CW-1:0] w_free;
    logic            w_acc1, w_acc3, w_acc5;
    logic [c_CW-1:0] w_n1, w_n3, w_nacc;
    logic            w_drop;
    logic [c_CW-1:0] w_count_next;
    logic [c_CW-1:0] w_free_next;
    logic [5:0]      w_set_flags;
    logic [c_AW-1:0] w_wa1, w_wa3, w_wa5;

    // Space is judged after this cycle's pop, so a full queue that drains
    // one entry can still accept one write in the same cycle.
    always_comb begin
        w_pop        = (r_count != '0) && out_rdy;
        w_free       = c_CW'(DEPTH) - r_count + c_CW'(w_pop);
        w_acc1       = u1_ret_en && (w_free != '0);
        w_n1         = c_CW'(w_acc1);
        w_acc3       = u3_ret_en && (w_free > w_n1);
        w_n3         = w_n1 + c_CW'(w_acc3);
        w_acc5       = u5_ret_en && (w_free > w_n3);
        w_nacc       = w_n3 + c_CW'(w_acc5);
        w_drop       = (u1_ret_en && !w_acc1) || (u3_ret_en && !w_acc3) ||
                       (u5_ret_en && !w_acc5);
        w_count_next = r_count + w_nacc - c_CW'(w_pop);
        w_free_next  = c_CW'(DEPTH) - w_count_next;
        w_set_flags  = (w_acc1 ? u1_ret[5:0] : 6'd0) |
                       (w_acc3 ? u3_ret[5:0] : 6'd0) |
                       (w_acc5 ? u5_ret[5:0] : 6'd0);
        // Accepted writes are packed into consecutive slots in u1, u3, u5 order.
        w_wa1        = r_wr_ptr;
        w_wa3        = r_wr_ptr + c_AW'(w_acc1);
        w_wa5        = r_wr_ptr + c_AW'(w_acc1) + c_AW'(w_acc3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_ret[i]  <= '0;
                r_mem_port[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_flags  <= '0;
            r_stall  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_acc1) begin
                r_mem_ret[w_wa1]  <= u1_ret;
                r_mem_port[w_wa1] <= 2'd0;
            end
            if (w_acc3) begin
                r_mem_ret[w_wa3]  <= u3_ret;
                r_mem_port[w_wa3] <= 2'd1;
            end
            if (w_acc5) begin
                r_mem_ret[w_wa5]  <= u5_ret;
                r_mem_port[w_wa5] <= 2'd2;
            end
            r_wr_ptr <= r_wr_ptr + w_nacc[c_AW-1:0];
            r_rd_ptr <= r_rd_ptr + c_AW'(w_pop);
            r_count  <= w_count_next;
            r_flags  <= (flags_clr ? 6'd0 : r_flags) | w_set_flags;
            r_stall  <= (w_free_next <= c_CW'(STALL_TH));
            r_ovf    <= r_ovf | w_drop;
        end
    end

    assign out_ret  = r_mem_ret[r_rd_ptr];
    assign out_port = r_mem_port[r_rd_ptr];
    assign out_vld  = (r_count != '0);
    assign fp_flags = r_flags;
    assign stall    = r_stall;
    assign ovf_err  = r_ovf;
    assign count    = r_count;

endmodule
`default_nettype wire
